// File: rtl/pipeline_stall_ctrl.sv
// Central pipeline sequencer: merges load-use stalls, ID branch flushes and a
// multi-cycle data-memory handshake into per-stage enable/bubble/flush controls,
// with start gating, memory timeout detection and a saturating stall counter.
module pipeline_stall_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TMO_W       = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             load_use_stall_i,
    input  logic             branch_taken_i,
    input  logic             mem_access_i,
    input  logic             mem_ready_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             exmem_we_o,
    output logic             memwb_we_o,
    output logic             busy_o,
    output logic             error_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {StIdle, StRun, StMemWait, StError} state_e;

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_q;
    logic             run_rules;

    // Next-state, timeout counter and Mealy output decode
    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q;
        run_rules     = 1'b0;
        pc_we_o       = 1'b0;
        ifid_we_o     = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        exmem_we_o    = 1'b0;
        memwb_we_o    = 1'b0;
        busy_o        = 1'b0;
        error_o       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StRun;
            end
            StRun: begin
                // Memory freeze outranks every other hazard
                if (mem_access_i && !mem_ready_i) begin
                    state_d = StMemWait;
                    tmo_d   = TMO_W'(1);
                end else begin
                    run_rules = 1'b1;
                end
            end
            StMemWait: begin
                busy_o = 1'b1;
                if (mem_ready_i) begin
                    run_rules = 1'b1;
                    tmo_d     = '0;
                    state_d   = StRun;
                end else if (tmo_q == TMO_W'(MEM_TIMEOUT)) begin
                    state_d = StError;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            StError: begin
                error_o = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // Memory term satisfied: load-use beats branch (ID re-evaluates the branch next cycle)
        if (run_rules) begin
            exmem_we_o = 1'b1;
            memwb_we_o = 1'b1;
            if (load_use_stall_i) begin
                idex_bubble_o = 1'b1;
            end else begin
                pc_we_o      = 1'b1;
                ifid_we_o    = 1'b1;
                ifid_flush_o = branch_taken_i;
            end
        end
    end

    // State and timeout counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    // Saturating count of active cycles in which the PC did not advance
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if ((state_q == StRun || state_q == StMemWait) && !pc_we_o &&
                     (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed vector table, hand
// sequences for saturation and mid-wait reset, then randomized run vs a model.
module tb_pipeline_stall_ctrl;

    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int unsigned TMO_W       = 8;
    localparam int unsigned CNT_W       = 4;
    localparam int          CNT_MAX     = 15;

    logic clk = 1'b0;
    logic rst = 1'b0, start = 1'b0, lu = 1'b0, br = 1'b0, ma = 1'b0, mr = 1'b0;
    logic pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we, busy, error;
    logic [CNT_W-1:0] stall_cnt;
    logic [7:0]       dut_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TMO_W      (TMO_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .load_use_stall_i(lu),
        .branch_taken_i  (br),
        .mem_access_i    (ma),
        .mem_ready_i     (mr),
        .pc_we_o         (pc_we),
        .ifid_we_o       (ifid_we),
        .ifid_flush_o    (ifid_flush),
        .idex_bubble_o   (idex_bubble),
        .exmem_we_o      (exmem_we),
        .memwb_we_o      (memwb_we),
        .busy_o          (busy),
        .error_o         (error),
        .stall_cnt_o     (stall_cnt)
    );

    // Output order: pc, ifid, flush, bubble, exmem, memwb, busy, error
    assign dut_out = {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we, busy, error};

    typedef struct {
        logic [5:0] in;   // rst, start, lu, br, ma, mr
        logic [7:0] out;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    // Inputs change on the falling edge; outputs are sampled 1 time unit later
    task automatic drive(input logic [5:0] v);
        @(negedge clk);
        {rst, start, lu, br, ma, mr} = v;
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] exp_out, input int exp_cnt);
        n_cmp++;
        if (dut_out !== exp_out) begin
            n_bad++;
            $display("FAIL %s: outputs got %b expected %b", name, dut_out, exp_out);
        end
        n_cmp++;
        if (int'(stall_cnt) != exp_cnt) begin
            n_bad++;
            $display("FAIL %s: stall_cnt got %0d expected %0d", name, stall_cnt, exp_cnt);
        end
    endtask

    // Reference model: pipeline status described as flags and a wait length
    bit m_running, m_waiting, m_dead;
    int m_wait_len, m_stalls;

    function automatic logic [7:0] model_out(input logic l, b, a, m);
        logic [7:0] o;
        o = 8'b0;
        if (m_dead)                       o[0] = 1'b1;
        else if (!m_running)              o = 8'b0;
        else if (m_waiting && !m)         o[1] = 1'b1;
        else if (!m_waiting && a && !m)   o = 8'b0;
        else begin
            o[1] = m_waiting;
            o[3] = 1'b1;                  // exmem
            o[2] = 1'b1;                  // memwb
            if (l) o[4] = 1'b1;           // bubble
            else begin
                o[7] = 1'b1;
                o[6] = 1'b1;
                o[5] = b;
            end
        end
        return o;
    endfunction

    task automatic model_step(input logic [5:0] v, input logic [7:0] exp_out);
        if (v[5]) begin
            m_running = 0; m_waiting = 0; m_dead = 0; m_wait_len = 0; m_stalls = 0;
            return;
        end
        if (m_running && !m_dead && !exp_out[7] && m_stalls < CNT_MAX) m_stalls++;
        if (m_dead) begin
            // sticky
        end else if (!m_running) begin
            m_running = v[4];
        end else if (m_waiting) begin
            if (v[0]) m_waiting = 0;
            else if (m_wait_len == int'(MEM_TIMEOUT)) m_dead = 1;
            else m_wait_len++;
        end else if (v[1] && !v[0]) begin
            m_waiting  = 1;
            m_wait_len = 1;
        end
    endtask

    initial begin
        logic [5:0] v;
        logic [7:0] e;

        // Directed table: {rst,start,lu,br,ma,mr}, expected outputs, expected count
        vecs.push_back('{6'b010000, 8'b00000000, 0});   // IDLE, start
        for (int i = 0; i < 5; i++)
            vecs.push_back('{6'b000000, 8'b11001100, 0}); // free run
        vecs.push_back('{6'b001000, 8'b00011100, 0});   // load-use
        vecs.push_back('{6'b000000, 8'b11001100, 1});
        vecs.push_back('{6'b001100, 8'b00011100, 1});   // load-use + branch
        vecs.push_back('{6'b000100, 8'b11101100, 2});   // branch alone flushes
        vecs.push_back('{6'b000010, 8'b00000000, 2});   // memory freeze in RUN
        vecs.push_back('{6'b000010, 8'b00000010, 3});   // MEM_WAIT
        vecs.push_back('{6'b000010, 8'b00000010, 4});
        vecs.push_back('{6'b000011, 8'b11001110, 5});   // ready in MEM_WAIT
        vecs.push_back('{6'b000000, 8'b11001100, 5});
        vecs.push_back('{6'b000011, 8'b11001100, 5});   // access completes at once
        vecs.push_back('{6'b000010, 8'b00000000, 5});
        vecs.push_back('{6'b001001, 8'b00011110, 6});   // ready + load-use in MEM_WAIT
        vecs.push_back('{6'b000000, 8'b11001100, 7});
        vecs.push_back('{6'b000010, 8'b00000000, 7});   // timeout sequence
        vecs.push_back('{6'b010010, 8'b00000010, 8});   // start ignored in MEM_WAIT
        vecs.push_back('{6'b000010, 8'b00000010, 9});
        vecs.push_back('{6'b000010, 8'b00000010, 10});
        vecs.push_back('{6'b000010, 8'b00000010, 11});  // counter at limit
        vecs.push_back('{6'b010011, 8'b00000001, 12});  // ERROR sticky
        vecs.push_back('{6'b000011, 8'b00000001, 12});
        vecs.push_back('{6'b100000, 8'b00000001, 12});  // reset edge
        vecs.push_back('{6'b000000, 8'b00000000, 0});   // back in IDLE
        vecs.push_back('{6'b000000, 8'b00000000, 0});

        drive(6'b100000);
        drive(6'b100000);
        foreach (vecs[i]) begin
            drive(vecs[i].in);
            check($sformatf("vec%0d", i), vecs[i].out, vecs[i].cnt);
        end

        // Counter saturation under a persistent load-use stall
        drive(6'b010000);
        check("sat_start", 8'b00000000, 0);
        for (int i = 0; i < 20; i++) begin
            drive(6'b001000);
            check($sformatf("sat%0d", i), 8'b00011100, (i < CNT_MAX) ? i : CNT_MAX);
        end
        drive(6'b000000);
        check("sat_hold", 8'b11001100, CNT_MAX);

        // Reset in the middle of MEM_WAIT
        drive(6'b000010);
        check("mw_enter", 8'b00000000, CNT_MAX);
        drive(6'b100010);
        check("mw_rst", 8'b00000010, CNT_MAX);
        drive(6'b000010);
        check("mw_idle", 8'b00000000, 0);
        drive(6'b010010);
        check("mw_restart", 8'b00000000, 0);
        drive(6'b000010);
        check("mw_run", 8'b00000000, 0);

        // Randomized run against the reference model
        drive(6'b100000);
        model_step(6'b100000, 8'b0);
        for (int i = 0; i < 3000; i++) begin
            v[5] = ($urandom_range(0, 299) == 0);
            v[4] = ($urandom_range(0, 3) == 0);
            v[3] = ($urandom_range(0, 3) == 0);
            v[2] = ($urandom_range(0, 3) == 0);
            v[1] = 1'($urandom_range(0, 1));
            v[0] = ($urandom_range(0, 9) > 2);
            e = model_out(v[3], v[2], v[1], v[0]);
            drive(v);
            check($sformatf("rnd%0d", i), e, m_stalls);
            model_step(v, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central pipeline sequencer for the 5-stage CPU. It merges the load-use stall request, the ID-stage branch-taken flush and a multi-cycle data-memory handshake into one consistent set of per-stage write-enable, bubble and flush controls. It also waits for the start command, detects memory timeouts and counts stall cycles. It sits beside the hazard detection logic and drives the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before entering ERROR (1..2^TMO_W-1)
TMO_W, 8, width of the timeout counter
CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk_i  input  1  system clock, all state updates on rising edge
rst_i  input  1  synchronous active-high reset
start_i  input  1  level; enables execution leaving IDLE
load_use_stall_i  input  1  load-use hazard request from hazard detection
branch_taken_i  input  1  branch resolved taken in ID this cycle
mem_access_i  input  1  instruction in MEM performs a load/store
mem_ready_i  input  1  data memory completes the access this cycle
pc_we_o  output  1  PC write enable
ifid_we_o  output  1  IF/ID register write enable
ifid_flush_o  output  1  clear IF/ID to NOP on next edge
idex_bubble_o  output  1  load NOP controls into ID/EX
exmem_we_o  output  1  EX/MEM register write enable
memwb_we_o  output  1  MEM/WB register write enable
busy_o  output  1  high in MEM_WAIT
error_o  output  1  high in ERROR
stall_cnt_o  output  CNT_W  saturating count of cycles with pc_we_o=0 in RUN or MEM_WAIT

Behaviour:
- The clock is clk_i. The reset is rst_i: synchronous, active-high. On reset: state=IDLE, timeout counter=0, stall_cnt_o=0.
- Outputs are combinational from the current state and the current inputs (Mealy), so they take effect on the same edge.
- IDLE: all write enables=0, flush=0, bubble=0, busy_o=0, error_o=0. Go to RUN when start_i=1; the first pipeline advance happens in the cycle after that.
- RUN: evaluate in this priority order.
  1. mem_access_i=1 and mem_ready_i=0 (memory freeze): all four write enables=0, bubble=0, flush=0. Next state=MEM_WAIT; the timeout counter loads 1.
  2. Otherwise, load_use_stall_i=1: pc_we_o=0, ifid_we_o=0, idex_bubble_o=1, exmem_we_o=1, memwb_we_o=1, ifid_flush_o=0. A simultaneous branch_taken_i is ignored, because ID re-evaluates it in the next cycle.
  3. Otherwise, branch_taken_i=1: all write enables=1 and ifid_flush_o=1.
  4. Otherwise: all write enables=1, bubble=0, flush=0.
- MEM_WAIT:
  - Outputs: all write enables=0, busy_o=1.
  - If mem_ready_i=1: outputs revert to the RUN rules with the memory term treated as satisfied (priorities 2–4 apply), the timeout counter clears, and next state=RUN.
  - Else if timeout counter == MEM_TIMEOUT: next state=ERROR.
  - Else: the timeout counter increments.
  - start_i is ignored in this state.
- ERROR: all write enables=0, error_o=1. Sticky; only rst_i exits.
- stall_cnt_o increments by 1 on each edge where the state is RUN or MEM_WAIT and pc_we_o=0. It saturates at 2^CNT_W-1 and does not wrap.
- Deasserting start_i in RUN has no effect. Execution continues until reset.
- rst_i asserted in any state, including mid MEM_WAIT, wins over every other input on that edge.

Test Plan:
1. Reset, start_i=1 pulse, then no hazards for 5 cycles -> IDLE for 1 cycle, then all write enables=1 for 5 cycles, stall_cnt_o=0.
2. RUN with load_use_stall_i=1 for one cycle -> that cycle pc_we_o=0, ifid_we_o=0, idex_bubble_o=1, exmem_we_o=1; next cycle all enables=1; stall_cnt_o=1.
3. load_use_stall_i=1 and branch_taken_i=1 in the same cycle -> ifid_flush_o=0, idex_bubble_o=1. Next cycle branch_taken_i=1 alone -> ifid_flush_o=1 and pc_we_o=1.
4. mem_access_i=1, mem_ready_i=0 for 3 cycles, then mem_ready_i=1 -> all enables=0 for 3 cycles with busy_o=1 in MEM_WAIT; enables=1 in the ready cycle; state=RUN; stall_cnt_o increases by 3.
5. MEM_TIMEOUT=4, mem_ready_i held 0 -> ERROR entered after the counter reaches 4. error_o=1 stays asserted despite a later mem_ready_i=1; rst_i returns the block to IDLE with stall_cnt_o=0.
6. CNT_W=4, load_use_stall_i held 1 for 20 cycles -> stall_cnt_o reaches 15 and stays at 15.
